stereo_sample_framer: RTL

Downstream consumer of the dual MCP3201 capture stage. Pairs the independent left and right 12-bit sample strobes into one stereo frame. Serialises each frame as a 4-byte tagged stream over a valid/ready byte interface, intended to feed the UART/USB transmit path. Buffers one complete frame and counts dropped frames and channel-skew events.

---
 rtl/stereo_sample_framer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/stereo_sample_framer.sv
// Pairs independent left/right 12-bit sample strobes into stereo frames and
// streams each frame as four tagged bytes; one frame in flight plus one pending.
module stereo_sample_framer #(
    parameter logic [3:0] LEFT_TAG  = 4'hA,
    parameter logic [3:0] RIGHT_TAG = 4'h5,
    parameter int         CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [11:0]          ldata,
    input  logic                 lstrb,
    input  logic [11:0]          rdata,
    input  logic                 rstrb,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [CNT_WIDTH-1:0] skew_cnt,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                state_q, state_d;
    logic [11:0]           lcap_q, lcap_d, rcap_q, rcap_d;
    logic                  lval_q, lval_d, rval_q, rval_d;
    logic                  pend_q, pend_d;
    logic [11:0]           pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic [11:0]           sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d, skew_q, skew_d;

    logic [11:0]           l_now, r_now;
    logic                  pair, accept, consume, skew_evt, drop_evt;

    // Stream handshake: a byte transfers in any cycle with out_valid && out_ready;
    // while out_valid && !out_ready, out_data and out_last hold their values and
    // out_valid stays high until the byte is taken.
    assign accept = out_valid && out_ready;

    // A strobing channel contributes its current-cycle data to the pair.
    always_comb begin
        l_now    = lstrb ? ldata : lcap_q;
        r_now    = rstrb ? rdata : rcap_q;
        pair     = (lval_q | lstrb) & (rval_q | rstrb);
        skew_evt = (lstrb & lval_q) | (rstrb & rval_q);
        consume  = pend_q && ((state_q == IDLE) || ((state_q == B3) && accept));
        drop_evt = pair & pend_q & ~consume;
    end

    always_comb begin
        lcap_d   = l_now;
        rcap_d   = r_now;
        lval_d   = pair ? 1'b0 : (lval_q | lstrb);
        rval_d   = pair ? 1'b0 : (rval_q | rstrb);
        pend_d   = pend_q & ~consume;
        pend_l_d = pend_l_q;
        pend_r_d = pend_r_q;
        if (pair && (!pend_q || consume)) begin
            pend_d   = 1'b1;
            pend_l_d = l_now;
            pend_r_d = r_now;
        end
        drop_d = (drop_evt && drop_q != CNT_MAX) ? drop_q + CNT_ONE : drop_q;
        skew_d = (skew_evt && skew_q != CNT_MAX) ? skew_q + CNT_ONE : skew_q;
    end

    always_comb begin
        state_d = state_q;
        sh_l_d  = sh_l_q;
        sh_r_d  = sh_r_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    sh_l_d  = pend_l_q;
                    sh_r_d  = pend_r_q;
                    state_d = B0;
                end
            end
            B0: if (accept) state_d = B1;
            B1: if (accept) state_d = B2;
            B2: if (accept) state_d = B3;
            B3: begin
                if (accept) begin
                    // Chain straight into the next frame to avoid an idle bubble.
                    if (pend_q) begin
                        sh_l_d  = pend_l_q;
                        sh_r_d  = pend_r_q;
                        state_d = B0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        case (state_q)
            B0: begin
                out_valid = 1'b1;
                out_data  = {LEFT_TAG, sh_l_q[11:8]};
            end
            B1: begin
                out_valid = 1'b1;
                out_data  = sh_l_q[7:0];
            end
            B2: begin
                out_valid = 1'b1;
                out_data  = {RIGHT_TAG, sh_r_q[11:8]};
            end
            B3: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = sh_r_q[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            lcap_q   <= 12'h000;
            rcap_q   <= 12'h000;
            lval_q   <= 1'b0;
            rval_q   <= 1'b0;
            pend_q   <= 1'b0;
            pend_l_q <= 12'h000;
            pend_r_q <= 12'h000;
            sh_l_q   <= 12'h000;
            sh_r_q   <= 12'h000;
            drop_q   <= '0;
            skew_q   <= '0;
        end else begin
            state_q  <= state_d;
            lcap_q   <= lcap_d;
            rcap_q   <= rcap_d;
            lval_q   <= lval_d;
            rval_q   <= rval_d;
            pend_q   <= pend_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            sh_l_q   <= sh_l_d;
            sh_r_q   <= sh_r_d;
            drop_q   <= drop_d;
            skew_q   <= skew_d;
        end
    end

    assign drop_cnt  = drop_q;
    assign skew_cnt  = skew_q;
    assign dbg_state = state_q;

endmodule
